mac_row_seq: RTL and testbench

//  Sequencer for one systolic MAC row: a COLUMN-wide macu chain whose activation

---
 rtl/mac_row_pkg.sv | 32 +++
 rtl/mac_row_vld_pipe.sv | 37 +++
 rtl/mac_row_seq.sv | 195 +++++++++++++++++++
 tb/tb_mac_row_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_row_pkg.sv
`default_nettype none
// ============================================================================
// Module : mac_row_pkg
// Brief  : Shared types and constants for the systolic MAC row sequencer.
//          Provides the sequencer state encoding, the default drain length
//          and a helper that derives the drain length from the row geometry.
// Rev    : 1.0  initial release
// ============================================================================
package mac_row_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Default row geometry and the matching drain length.
    localparam int DEF_COLUMN  = 6;
    localparam int DEF_MAC_LAT = 1;
    localparam int DRAIN_CYC   = DEF_COLUMN - 1 + DEF_MAC_LAT;

    // The final activation needs COLUMN-1 clocks to ripple to the last
    // column plus MAC_LAT clocks to appear on that column's co.
    function automatic int drain_cycles(input int column, input int mac_lat);
        return column - 1 + mac_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_row_vld_pipe.sv
`default_nettype none
// ============================================================================
// Module : mac_row_vld_pipe
// Brief  : Valid shift chain that follows the activation as it ripples along
//          the MAC row. Every tap is exposed so the top can pick the slot
//          matching each column's result timing.
// Ports  : clk    in  clock
//          rst_n  in  asynchronous active-low reset, clears the whole chain
//          vld_in in  valid for the activation presented this cycle
//          taps   out taps[k] = vld_in delayed k+1 clocks
// Rev    : 1.0  initial release
// ============================================================================
module mac_row_vld_pipe #(
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_in,
    output logic [DEPTH-1:0] taps
);

    logic [DEPTH-1:0] r_v;

    // Chain advances every clock, bubbles included, so a stale valid can
    // never linger once the row has shifted past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else begin
            r_v <= {r_v[DEPTH-2:0], vld_in};
        end
    end

    assign taps = r_v;

endmodule
`default_nettype wire

// File: rtl/mac_row_seq.sv
`default_nettype none
// ============================================================================
// Module : mac_row_seq
// Brief  : Sequencer for one systolic MAC row. Per job it loads COLUMN
//          weights (one column per handshake), streams LEN activations into
//          the row's xi and raises per-column result-valid strobes aligned
//          with each column's co output.
// Ports  : clk, rst_n          clock / asynchronous active-low reset
//          start, len          job start pulse (IDLE only) and activation count
//          w_data/w_valid/w_ready  weight stream handshake
//          x_data/x_valid/x_ready  activation stream handshake
//          row_xi, row_wi, row_w_en  drive the MAC row
//          col_valid           per-column result valid
//          busy, done          job status
// Rev    : 1.0  initial release
// ============================================================================
module mac_row_seq
    import mac_row_pkg::*;
#(
    parameter int DW      = 8,
    parameter int WW      = 8,
    parameter int COLUMN  = 6,
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic [WW-1:0]        w_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DW-1:0]        x_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic [DW-1:0]        row_xi,
    output logic [COLUMN*WW-1:0] row_wi,
    output logic [COLUMN-1:0]    row_w_en,
    output logic [COLUMN-1:0]    col_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int C_DRAIN  = drain_cycles(COLUMN, MAC_LAT);
    localparam int C_WCNT_W = (COLUMN > 1) ? $clog2(COLUMN) : 1;
    localparam int C_DCNT_W = $clog2(C_DRAIN + 1);
    // Only taps 0..COLUMN+MAC_LAT-2 feed a column, so the chain stops there.
    localparam int C_VDEPTH = COLUMN + MAC_LAT - 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_WCNT_W-1:0]  r_wcnt;
    logic [LEN_W-1:0]     r_rem;
    logic [C_DCNT_W-1:0]  r_dcnt;

    logic                 w_w_acc;
    logic                 w_x_acc;
    logic                 w_wcnt_last;
    logic                 w_dcnt_last;
    logic [COLUMN-1:0]    w_onehot;
    logic [C_VDEPTH-1:0]  w_taps;

    // ------------------------------------------------------------------
    // Handshakes: the two readies are decoded from disjoint states, so
    // they can never be high together.
    // ------------------------------------------------------------------
    assign w_ready     = (r_state == ST_LOAD);
    assign x_ready     = (r_state == ST_STREAM);
    assign w_w_acc     = w_valid & w_ready;
    assign w_x_acc     = x_valid & x_ready;
    assign w_wcnt_last = (r_wcnt == C_WCNT_W'(COLUMN - 1));
    assign w_dcnt_last = (r_dcnt == C_DCNT_W'(C_DRAIN - 1));

    // ------------------------------------------------------------------
    // Row drive. xi is combinational so the macu samples the activation on
    // the same edge that accepts it; a non-accepted cycle injects a zero
    // bubble while the row keeps shifting.
    // ------------------------------------------------------------------
    assign w_onehot = {{(COLUMN-1){1'b0}}, 1'b1} << r_wcnt;
    assign row_w_en = w_w_acc ? w_onehot : '0;
    assign row_wi   = {COLUMN{w_data}};
    assign row_xi   = w_x_acc ? x_data : '0;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (w_w_acc && w_wcnt_last) begin
                    // An empty job skips streaming so rem never underflows.
                    w_state_nxt = (r_rem == '0) ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (w_x_acc && (r_rem == LEN_W'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_dcnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job counters: weight column index, remaining activations, drain count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_rem  <= '0;
            r_dcnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rem  <= len;
                        r_wcnt <= '0;
                        r_dcnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_w_acc) begin
                        r_wcnt <= w_wcnt_last ? '0 : r_wcnt + C_WCNT_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (w_x_acc) begin
                        r_rem <= r_rem - LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_dcnt <= w_dcnt_last ? '0 : r_dcnt + C_DCNT_W'(1);
                end
                default: begin
                    r_dcnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result-valid alignment: an accept at cycle t reaches column i's co at
    // t+i+MAC_LAT, which is tap i+MAC_LAT-1 of the chain.
    // ------------------------------------------------------------------
    mac_row_vld_pipe #(
        .DEPTH (C_VDEPTH)
    ) u_vld_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_in (w_x_acc),
        .taps   (w_taps)
    );

    generate
        for (genvar gi = 0; gi < COLUMN; gi++) begin : g_col_valid
            assign col_valid[gi] = w_taps[gi + MAC_LAT - 1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_row_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_row_seq
// Brief  : Self-checking bench for mac_row_seq. Random jobs are checked every
//          cycle against a transaction-level model that tracks how many
//          weights/activations each job has taken and when each activation
//          was accepted.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mac_row_seq;

    localparam int DW      = 8;
    localparam int WW      = 8;
    localparam int COLUMN  = 6;
    localparam int LEN_W   = 16;
    localparam int MAC_LAT = 1;
    localparam int NCYC    = 4000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [LEN_W-1:0]     len;
    logic [WW-1:0]        w_data;
    logic                 w_valid;
    logic                 w_ready;
    logic [DW-1:0]        x_data;
    logic                 x_valid;
    logic                 x_ready;
    logic [DW-1:0]        row_xi;
    logic [COLUMN*WW-1:0] row_wi;
    logic [COLUMN-1:0]    row_w_en;
    logic [COLUMN-1:0]    col_valid;
    logic                 busy;
    logic                 done;

    mac_row_seq #(
        .DW(DW), .WW(WW), .COLUMN(COLUMN), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .row_xi(row_xi), .row_wi(row_wi), .row_w_en(row_w_en),
        .col_valid(col_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int  cyc         = 0;
    bit  m_active    = 0;
    int  m_wacc      = 0;
    int  m_xacc      = 0;
    int  m_len       = 0;
    int  m_done_cyc  = -1;
    int  m_clear_cyc = 0;
    bit  acc_at[NCYC];
    int  job_num     = 0;
    int  cur_mode    = 0;
    int  p_idx       = 0;
    int  rst_cnt     = 2;
    bit  did_midrst  = 0;
    bit  w_tog       = 0;
    int  jobs_done   = 0;
    bit  x_pat[6]    = '{1, 0, 1, 1, 0, 1};

    bit                e_wr, e_xr, e_busy, e_done, w_acc, x_acc;
    logic [COLUMN-1:0] e_wen, e_cv;
    logic [DW-1:0]     e_xi;

    function automatic int mode_of(input int jn);
        if (jn <= 2 || jn == 5) return jn;
        return 3;
    endfunction

    function automatic int len_of(input int jn);
        case (jn)
            0:       return 4;
            1:       return 0;
            2:       return 3;
            5:       return 6;
            default: return $urandom_range(0, 9);
        endcase
    endfunction

    function automatic bit in_stream();
        return m_active && (m_wacc == COLUMN) && (m_xacc < m_len);
    endfunction

    task automatic model_reset();
        m_active    = 0;
        m_wacc      = 0;
        m_xacc      = 0;
        m_done_cyc  = -1;
        m_clear_cyc = cyc;
    endtask

    task automatic compute_exp();
        e_busy = m_active;
        e_done = m_active && (m_done_cyc == cyc);
        e_wr   = m_active && (m_wacc < COLUMN);
        e_xr   = in_stream();
        w_acc  = w_valid && e_wr;
        x_acc  = x_valid && e_xr;
        e_wen  = w_acc ? COLUMN'(1 << m_wacc) : '0;
        e_xi   = x_acc ? x_data : '0;
        for (int i = 0; i < COLUMN; i++) begin
            int src;
            src = cyc - i - MAC_LAT;
            e_cv[i] = (src >= 0) && (src >= m_clear_cyc) && acc_at[src];
        end
    endtask

    task automatic model_update();
        if (e_done) begin
            m_active = 0;
            jobs_done++;
        end else if (!m_active && start) begin
            m_active   = 1;
            m_len      = int'(len);
            m_wacc     = 0;
            m_xacc     = 0;
            m_done_cyc = -1;
            p_idx      = 0;
            cur_mode   = mode_of(job_num);
            job_num++;
        end
        if (w_acc) begin
            m_wacc++;
            if (m_wacc == COLUMN && m_len == 0) m_done_cyc = cyc + COLUMN + MAC_LAT;
        end
        if (x_acc) begin
            m_xacc++;
            if (m_xacc == m_len) m_done_cyc = cyc + COLUMN + MAC_LAT;
        end
        acc_at[cyc] = x_acc;
    endtask

    task automatic drive_inputs();
        // One reset in the middle of job 5's activation stream.
        if (!did_midrst && job_num == 6 && in_stream() && m_xacc >= 1) begin
            did_midrst = 1;
            rst_cnt    = 2;
        end
        if (rst_cnt > 0) begin
            rst_n = 1'b0;
            rst_cnt--;
        end else begin
            rst_n = 1'b1;
        end

        if (!m_active) begin
            start = ($urandom_range(0, 2) == 0);
            len   = LEN_W'(len_of(job_num));
        end else begin
            start = ($urandom_range(0, 2) == 0);   // must be ignored
            len   = LEN_W'($urandom);              // must not affect the job
        end
        if (!rst_n) start = 1'b0;

        w_data = WW'($urandom);
        x_data = DW'($urandom);
        w_tog  = ~w_tog;
        case (cur_mode)
            0, 1:    w_valid = 1'b1;
            2:       w_valid = w_tog;
            default: w_valid = ($urandom_range(0, 9) < 7);
        endcase
        if (cur_mode == 0) begin
            x_valid = (p_idx < 6) ? x_pat[p_idx] : 1'b1;
        end else begin
            x_valid = ($urandom_range(0, 9) < 6);
        end
        if (in_stream()) p_idx++;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        len     = '0;
        w_data  = '0;
        w_valid = 1'b0;
        x_data  = '0;
        x_valid = 1'b0;
        #1;
        for (int c = 0; c < NCYC; c++) begin
            drive_inputs();
            if (!rst_n) begin
                #0;
                model_reset();
            end
            @(negedge clk);
            compute_exp();
            check("busy",      64'(busy),      64'(e_busy));
            check("done",      64'(done),      64'(e_done));
            check("w_ready",   64'(w_ready),   64'(e_wr));
            check("x_ready",   64'(x_ready),   64'(e_xr));
            check("row_w_en",  64'(row_w_en),  64'(e_wen));
            check("row_xi",    64'(row_xi),    64'(e_xi));
            check("col_valid", 64'(col_valid), 64'(e_cv));
            check("row_wi",    64'(row_wi),    64'({COLUMN{w_data}}));
            @(posedge clk);
            if (rst_n) model_update();
            cyc++;
            #1;
        end
        check("midjob_reset_seen", 64'(did_midrst), 64'(1));
        check("jobs_completed_min", 64'(jobs_done >= 20), 64'(1));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
